// File: rtl/myriscv_pkg.sv
// Shared decode definitions for the myriscv core: ALU operator codes, RV32I opcodes,
// load/store width codes and the decoded bundle handed from decode to execute.
package myriscv_pkg;

    localparam logic [5:0] ALU_ADD  = 6'b011000;
    localparam logic [5:0] ALU_SUB  = 6'b011001;
    localparam logic [5:0] ALU_XOR  = 6'b101111;
    localparam logic [5:0] ALU_OR   = 6'b101110;
    localparam logic [5:0] ALU_AND  = 6'b010101;
    localparam logic [5:0] ALU_SLL  = 6'b100111;
    localparam logic [5:0] ALU_SRL  = 6'b100101;
    localparam logic [5:0] ALU_SRA  = 6'b100100;
    localparam logic [5:0] ALU_SLT  = 6'b000010;
    localparam logic [5:0] ALU_SLTU = 6'b000011;
    localparam logic [5:0] ALU_EQ   = 6'b001100;
    localparam logic [5:0] ALU_NE   = 6'b001101;
    localparam logic [5:0] ALU_LT   = 6'b000000;
    localparam logic [5:0] ALU_GE   = 6'b001010;
    localparam logic [5:0] ALU_LTU  = 6'b000001;
    localparam logic [5:0] ALU_GEU  = 6'b001011;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SHAMT
    } imm_sel_e;

    typedef struct packed {
        logic [5:0]  alu_op;
        logic        op_b_imm;
        logic        op_a_pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        wb_en;
        logic        mem_req;
        logic        mem_we;
        logic [2:0]  mem_size;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        illegal;
    } decode_t;

    // Content of an empty output slot: everything zero except the idle ALU operator.
    function automatic decode_t bubble_bundle(input logic [5:0] alu_op);
        decode_t b;
        b = '0;
        b.alu_op = alu_op;
        return b;
    endfunction

endpackage

// File: rtl/myriscv_imm_gen.sv
// Combinational RV32I immediate extraction; the format is chosen by the decoder.
module myriscv_imm_gen
    import myriscv_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_sel_e    imm_sel,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_sel)
            IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:     imm = {instr[31:12], 12'b0};
            IMM_J:     imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_SHAMT: imm = {27'b0, instr[24:20]};
            default:   imm = '0;
        endcase
    end

endmodule

// File: rtl/myriscv_decode_stage.sv
// RV32I decode stage with a registered valid/ready output bundle.
// Define DECODE_SKID_EN for a 2-entry skid buffer with a registered instr_ready_o.
module myriscv_decode_stage
    import myriscv_pkg::*;
#(
    parameter logic [5:0] RESET_ALU_OP = 6'b011000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [5:0]  alu_op_o,
    output logic        op_b_imm_o,
    output logic        op_a_pc_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic [31:0] imm_o,
    output logic        wb_en_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [2:0]  mem_size_o,
    output logic        branch_o,
    output logic        jal_o,
    output logic        jalr_o,
    output logic        illegal_o
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    imm_sel_e   imm_sel;
    logic [31:0] imm;
    logic       legal;
    logic       wb;
    decode_t    dec_raw;
    decode_t    dec;
    decode_t    out_q;
    logic       out_valid_q;
    logic       accept;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    myriscv_imm_gen u_imm_gen (
        .instr   (instr_i[31:7]),
        .imm_sel (imm_sel),
        .imm     (imm)
    );

    // Unused register fields are zeroed so downstream hazard checks see x0.
    always_comb begin
        dec_raw        = bubble_bundle(ALU_ADD);
        imm_sel        = IMM_NONE;
        legal          = 1'b1;
        wb             = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec_raw.rd       = instr_i[11:7];
                dec_raw.op_b_imm = 1'b1;
                wb               = 1'b1;
                imm_sel          = IMM_U;
            end
            OPC_AUIPC: begin
                dec_raw.rd       = instr_i[11:7];
                dec_raw.op_a_pc  = 1'b1;
                dec_raw.op_b_imm = 1'b1;
                wb               = 1'b1;
                imm_sel          = IMM_U;
            end
            OPC_JAL: begin
                dec_raw.rd       = instr_i[11:7];
                dec_raw.op_a_pc  = 1'b1;
                dec_raw.op_b_imm = 1'b1;
                dec_raw.jal      = 1'b1;
                wb               = 1'b1;
                imm_sel          = IMM_J;
            end
            OPC_JALR: begin
                dec_raw.rd       = instr_i[11:7];
                dec_raw.rs1      = instr_i[19:15];
                dec_raw.op_b_imm = 1'b1;
                dec_raw.jalr     = 1'b1;
                wb               = 1'b1;
                imm_sel          = IMM_I;
            end
            OPC_BRANCH: begin
                dec_raw.rs1    = instr_i[19:15];
                dec_raw.rs2    = instr_i[24:20];
                dec_raw.branch = 1'b1;
                imm_sel        = IMM_B;
                case (f3)
                    3'b000:  dec_raw.alu_op = ALU_EQ;
                    3'b001:  dec_raw.alu_op = ALU_NE;
                    3'b100:  dec_raw.alu_op = ALU_LT;
                    3'b101:  dec_raw.alu_op = ALU_GE;
                    3'b110:  dec_raw.alu_op = ALU_LTU;
                    3'b111:  dec_raw.alu_op = ALU_GEU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec_raw.rd       = instr_i[11:7];
                dec_raw.rs1      = instr_i[19:15];
                dec_raw.op_b_imm = 1'b1;
                dec_raw.mem_req  = 1'b1;
                dec_raw.mem_size = f3;
                wb               = 1'b1;
                imm_sel          = IMM_I;
                legal            = (f3 == LS_B) || (f3 == LS_H) || (f3 == LS_W) ||
                                   (f3 == LS_BU) || (f3 == LS_HU);
            end
            OPC_STORE: begin
                dec_raw.rs1      = instr_i[19:15];
                dec_raw.rs2      = instr_i[24:20];
                dec_raw.op_b_imm = 1'b1;
                dec_raw.mem_req  = 1'b1;
                dec_raw.mem_we   = 1'b1;
                dec_raw.mem_size = f3;
                imm_sel          = IMM_S;
                legal            = (f3 == LS_B) || (f3 == LS_H) || (f3 == LS_W);
            end
            OPC_OP_IMM: begin
                dec_raw.rd       = instr_i[11:7];
                dec_raw.rs1      = instr_i[19:15];
                dec_raw.op_b_imm = 1'b1;
                wb               = 1'b1;
                imm_sel          = IMM_I;
                case (f3)
                    3'b000: dec_raw.alu_op = ALU_ADD;
                    3'b010: dec_raw.alu_op = ALU_SLT;
                    3'b011: dec_raw.alu_op = ALU_SLTU;
                    3'b100: dec_raw.alu_op = ALU_XOR;
                    3'b110: dec_raw.alu_op = ALU_OR;
                    3'b111: dec_raw.alu_op = ALU_AND;
                    3'b001: begin
                        dec_raw.alu_op = ALU_SLL;
                        imm_sel        = IMM_SHAMT;
                        legal          = (f7 == F7_BASE);
                    end
                    default: begin
                        dec_raw.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        imm_sel        = IMM_SHAMT;
                        legal          = (f7 == F7_BASE) || (f7 == F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                dec_raw.rd  = instr_i[11:7];
                dec_raw.rs1 = instr_i[19:15];
                dec_raw.rs2 = instr_i[24:20];
                wb          = 1'b1;
                case (f3)
                    3'b000:  dec_raw.alu_op = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    3'b001:  dec_raw.alu_op = ALU_SLL;
                    3'b010:  dec_raw.alu_op = ALU_SLT;
                    3'b011:  dec_raw.alu_op = ALU_SLTU;
                    3'b100:  dec_raw.alu_op = ALU_XOR;
                    3'b101:  dec_raw.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    3'b110:  dec_raw.alu_op = ALU_OR;
                    default: dec_raw.alu_op = ALU_AND;
                endcase
                legal = (f7 == F7_BASE) ||
                        ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            default: legal = 1'b0;
        endcase
        if (instr_i[1:0] != 2'b11) begin
            legal = 1'b0;
        end
        dec_raw.wb_en = wb && (instr_i[11:7] != 5'd0);
    end

    // Illegal words still travel as a valid bundle so execute can raise the trap.
    always_comb begin
        dec     = dec_raw;
        dec.imm = imm;
        if (!legal) begin
            dec.alu_op  = ALU_ADD;
            dec.wb_en   = 1'b0;
            dec.mem_req = 1'b0;
            dec.mem_we  = 1'b0;
            dec.branch  = 1'b0;
            dec.jal     = 1'b0;
            dec.jalr    = 1'b0;
            dec.illegal = 1'b1;
        end
    end

`ifdef DECODE_SKID_EN
    decode_t skid_q;
    logic    skid_valid_q;
    logic    ready_q;

    assign instr_ready_o = ready_q;
    assign accept        = instr_valid_i && ready_q;

    // ready_q always mirrors !skid_valid_q but comes straight from a flop.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            out_valid_q  <= 1'b0;
            out_q        <= bubble_bundle(RESET_ALU_OP);
            skid_valid_q <= 1'b0;
            skid_q       <= bubble_bundle(RESET_ALU_OP);
            ready_q      <= 1'b1;
        end else if (!out_valid_q || out_ready_i) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
                ready_q      <= 1'b1;
            end else if (accept) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                out_q       <= bubble_bundle(RESET_ALU_OP);
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
            ready_q      <= 1'b0;
        end
    end
`else
    assign instr_ready_o = !out_valid_q || out_ready_i;
    assign accept        = instr_valid_i && instr_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            out_valid_q <= 1'b0;
            out_q       <= bubble_bundle(RESET_ALU_OP);
        end else if (accept) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
        end else if (out_ready_i) begin
            out_q       <= bubble_bundle(RESET_ALU_OP);
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign out_valid_o = out_valid_q;
    assign alu_op_o    = out_q.alu_op;
    assign op_b_imm_o  = out_q.op_b_imm;
    assign op_a_pc_o   = out_q.op_a_pc;
    assign rs1_o       = out_q.rs1;
    assign rs2_o       = out_q.rs2;
    assign rd_o        = out_q.rd;
    assign imm_o       = out_q.imm;
    assign wb_en_o     = out_q.wb_en;
    assign mem_req_o   = out_q.mem_req;
    assign mem_we_o    = out_q.mem_we;
    assign mem_size_o  = out_q.mem_size;
    assign branch_o    = out_q.branch;
    assign jal_o       = out_q.jal;
    assign jalr_o      = out_q.jalr;
    assign illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_myriscv_decode_stage.sv
// Directed bench for myriscv_decode_stage: field decode, illegal words, stall, flush and reset.
module tb_myriscv_decode_stage;

`ifdef DECODE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, instr_valid, instr_ready, out_valid, out_ready;
    logic [31:0] instr, imm;
    logic [5:0]  alu_op;
    logic        op_b_imm, op_a_pc, wb_en, mem_req, mem_we, branch, jal, jalr, illegal;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  mem_size;
    logic        fire;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    myriscv_decode_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .instr_i       (instr),
        .instr_valid_i (instr_valid),
        .instr_ready_o (instr_ready),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .alu_op_o      (alu_op),
        .op_b_imm_o    (op_b_imm),
        .op_a_pc_o     (op_a_pc),
        .rs1_o         (rs1),
        .rs2_o         (rs2),
        .rd_o          (rd),
        .imm_o         (imm),
        .wb_en_o       (wb_en),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_size_o    (mem_size),
        .branch_o      (branch),
        .jal_o         (jal),
        .jalr_o        (jalr),
        .illegal_o     (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        instr       = w;
        instr_valid = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; instr = '0; instr_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_alu", alu_op, 6'b011000);
        chk("rst_imm", imm, 0);
        chk("rst_rd", rd, 0);
        chk("rst_wb", wb_en, 0);
        chk("rst_illegal", illegal, 0);
        rst = 1'b0;
        #1;
        chk("rst_ready", instr_ready, 1);

        send(32'h00500093);
        chk("addi_valid", out_valid, 1);
        chk("addi_alu", alu_op, 6'b011000);
        chk("addi_rd", rd, 1);
        chk("addi_rs1", rs1, 0);
        chk("addi_imm", imm, 5);
        chk("addi_opb", op_b_imm, 1);
        chk("addi_wb", wb_en, 1);

        send(32'h40208133);
        chk("sub_alu", alu_op, 6'b011001);
        chk("sub_rs1", rs1, 1);
        chk("sub_rs2", rs2, 2);
        chk("sub_rd", rd, 2);
        chk("sub_opb", op_b_imm, 0);
        chk("sub_illegal", illegal, 0);

        send(32'h00208463);
        chk("beq_alu", alu_op, 6'b001100);
        chk("beq_imm", imm, 8);
        chk("beq_branch", branch, 1);
        chk("beq_wb", wb_en, 0);

        send(32'hFFFFFFFF);
        chk("ill_valid", out_valid, 1);
        chk("ill_flag", illegal, 1);
        chk("ill_alu", alu_op, 6'b011000);
        chk("ill_en", {wb_en, mem_req, mem_we, branch, jal, jalr}, 0);

        send(32'h0020A223);
        chk("sw_mem", {mem_req, mem_we, wb_en}, 3'b110);
        chk("sw_size", mem_size, 2);
        chk("sw_imm", imm, 4);
        chk("sw_rs2", rs2, 2);

        send(32'h4030D293);
        chk("srai_alu", alu_op, 6'b100100);
        chk("srai_imm", imm, 3);
        chk("srai_illegal", illegal, 0);

        send(32'h40309293);
        chk("slli_f7_illegal", illegal, 1);
        chk("slli_f7_wb", wb_en, 0);

        send(32'h123453B7);
        chk("lui_imm", imm, 32'h12345000);
        chk("lui_rs1", rs1, 0);
        chk("lui_opb", op_b_imm, 1);
        chk("lui_wb", wb_en, 1);

        send(32'h010000EF);
        chk("jal_flags", {jal, op_a_pc, op_b_imm, wb_en}, 4'b1111);
        chk("jal_imm", imm, 16);

        send(32'h00000013);
        chk("nop_wb", wb_en, 0);
        chk("nop_illegal", illegal, 0);

        send(32'h0020A463);
        chk("bf3_illegal", illegal, 1);
        chk("bf3_branch", branch, 0);

        // Load P = lw x3,-4(x1), then stall with Q = srai x5 pending.
        send(32'hFFC0A183);
        chk("lw_imm", imm, 32'hFFFFFFFC);
        chk("lw_mem", {mem_req, mem_we, wb_en}, 3'b101);
        chk("lw_size", mem_size, 2);
        out_ready = 1'b0;
        instr = 32'h4030D293; instr_valid = 1'b1;
        #1;
        chk("stall_ready_first", instr_ready, SKID);
        for (int i = 0; i < 3; i++) begin
            fire = instr_valid && instr_ready;
            tick();
            if (fire) instr_valid = 1'b0;
            #1;
            chk("stall_rd", rd, 3);
            chk("stall_valid", out_valid, 1);
        end
        chk("stall_ready_low", instr_ready, 0);
        out_ready = 1'b1;
        #1;
        fire = instr_valid && instr_ready;
        tick();
        if (fire) instr_valid = 1'b0;
        chk("release_rd", rd, 5);
        chk("release_alu", alu_op, 6'b100100);
        chk("release_valid", out_valid, 1);
        tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_alu", alu_op, 6'b011000);
        chk("drain_rd", rd, 0);

        // Flush while stalled with a new instruction offered.
        send(32'h00500093);
        out_ready = 1'b0;
        instr = 32'h40208133; instr_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; instr_valid = 1'b0;
        chk("flush_stall_valid", out_valid, 0);
        out_ready = 1'b1;
        tick();
        chk("flush_no_leak", out_valid, 0);
        chk("flush_ready", instr_ready, 1);

        instr = 32'h00500093; instr_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; instr_valid = 1'b0;
        chk("flush_wins", out_valid, 0);

        // Reset with a valid bundle held.
        send(32'h00500093);
        instr_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        tick();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_alu", alu_op, 6'b011000);
        chk("mrst_fields", {rd, rs1, op_b_imm, wb_en}, 0);
        chk("mrst_imm", imm, 0);
        rst = 1'b0;
        tick();
        chk("mrst_ready", instr_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
